// File: rtl/cdc_toggle_handshake_receiver.sv
// cdc_toggle_handshake_receiver
//   Destination-domain end of a toggle req/ack CDC bus transfer. Detects a
//   change on the already-synchronized request toggle and captures the data
//   bus that the sender holds. It presents the word on a valid/ready
//   interface. On accept it flips ack_toggle back toward the sender.
//
//   Build option: define CDC_RX_OVERRUN_DETECT_EN to add the sticky overrun
//   port. That flag is set by a request edge that arrives while a word is
//   still pending.
//
// Ports
//   clk        destination-domain clock
//   rst        synchronous, active-high reset
//   enable     1 = block advances, 0 = all state frozen
//   req_sync   request toggle (synchronizer output)
//   data_in    sender data, stable from req toggle until ack toggle seen
//   out_data   captured word, stable while out_valid=1
//   out_valid  word available
//   out_ready  consumer accepts word
//   ack_toggle acknowledge toggle back to the sender domain
//   busy       1 while a word is pending (state VALID)
//   overrun    sticky protocol-violation flag (CDC_RX_OVERRUN_DETECT_EN only)
module cdc_toggle_handshake_receiver #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  req_sync,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ack_toggle,
  output logic                  busy
`ifdef CDC_RX_OVERRUN_DETECT_EN
  ,
  output logic                  overrun
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t                state, state_next;
  logic                  req_prev, req_prev_next;
  logic [DATA_WIDTH-1:0] out_data_next;
  logic                  out_valid_next;
  logic                  ack_toggle_next;
  logic                  busy_next;
  logic                  req_edge;

  // Request edge relative to the last toggle level we consumed
  assign req_edge = req_sync ^ req_prev;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_prev   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      ack_toggle <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      req_prev   <= req_prev_next;
      out_data   <= out_data_next;
      out_valid  <= out_valid_next;
      ack_toggle <= ack_toggle_next;
      busy       <= busy_next;
    end
  end

  // Next-state and next-output logic. When enable is low every value holds.
  always_comb begin
    state_next      = state;
    req_prev_next   = req_prev;
    out_data_next   = out_data;
    out_valid_next  = out_valid;
    ack_toggle_next = ack_toggle;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (req_edge) begin
            out_data_next  = data_in;
            req_prev_next  = req_sync;
            out_valid_next = 1'b1;
            state_next     = VALID;
          end
        end
        VALID: begin
          // req_prev is left alone here. An early edge therefore stays
          // pending and is captured after the current word is accepted.
          if (out_valid && out_ready) begin
            out_valid_next  = 1'b0;
            ack_toggle_next = ~ack_toggle;
            state_next      = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next == VALID);
  end

`ifdef CDC_RX_OVERRUN_DETECT_EN
  logic overrun_next;

  // Sticky flag: the sender toggled again before our ack
  always_comb begin
    overrun_next = overrun;
    if (enable && (state == VALID) && req_edge) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun_next;
    end
  end
`endif

endmodule

// File: tb/tb_cdc_toggle_handshake_receiver.sv
// Directed bench for cdc_toggle_handshake_receiver. Inputs are driven 1 ns
// after a rising edge. Outputs are sampled 1 ns after the following edge.
module tb_cdc_toggle_handshake_receiver;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          req_sync;
  logic [DW-1:0] data_in;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          ack_toggle;
  logic          busy;
`ifdef CDC_RX_OVERRUN_DETECT_EN
  logic          overrun;
`endif

  int checks = 0;
  int errors = 0;

  cdc_toggle_handshake_receiver #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req_sync   (req_sync),
    .data_in    (data_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ack_toggle (ack_toggle),
    .busy       (busy)
`ifdef CDC_RX_OVERRUN_DETECT_EN
    ,
    .overrun    (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; req_sync = 1'b0; data_in = 8'h00; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_ack", 32'(ack_toggle), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef CDC_RX_OVERRUN_DETECT_EN
    check("rst_overrun", 32'(overrun), 32'd0);
`endif

    // 1: basic transfer
    data_in = 8'hA5; req_sync = 1'b1;
    step();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'hA5);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ack_hold", 32'(ack_toggle), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_valid_clr", 32'(out_valid), 32'd0);
    check("t1_ack", 32'(ack_toggle), 32'd1);
    check("t1_busy_clr", 32'(busy), 32'd0);

    // 2: backpressure for 10 cycles
    data_in = 8'h3C; req_sync = 1'b0;
    step();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_data", 32'(out_data), 32'h3C);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_data", 32'(out_data), 32'h3C);
      check("t2_hold_ack", 32'(ack_toggle), 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_valid_clr", 32'(out_valid), 32'd0);
    check("t2_ack", 32'(ack_toggle), 32'd0);

    // 3: enable gating
    enable = 1'b0; data_in = 8'h5A; req_sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_no_capture", 32'(out_valid), 32'd0);
    end
    enable = 1'b1;
    step();
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_data", 32'(out_data), 32'h5A);
    enable = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("t3_frozen_valid", 32'(out_valid), 32'd1);
    check("t3_frozen_ack", 32'(ack_toggle), 32'd0);
    enable = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_valid_clr", 32'(out_valid), 32'd0);
    check("t3_ack", 32'(ack_toggle), 32'd1);

    // 4: four sequential transfers starting from reset (sender resets too)
    rst = 1'b1; req_sync = 1'b0;
    step();
    rst = 1'b0;
    check("t4_rst_ack", 32'(ack_toggle), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] word;
      word = DW'((i + 1) * 8'h11);
      data_in = word; req_sync = ~req_sync;
      step();
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_data", 32'(out_data), 32'(word));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t4_valid_clr", 32'(out_valid), 32'd0);
      check("t4_ack", 32'(ack_toggle), 32'((i + 1) % 2));
    end
    check("t4_ack_final", 32'(ack_toggle), 32'd0);

    // 5: sender toggles again while a word is pending
    data_in = 8'h77; req_sync = ~req_sync;
    step();
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_data", 32'(out_data), 32'h77);
    data_in = 8'h88; req_sync = ~req_sync;
    step();
    check("t5_no_overwrite", 32'(out_data), 32'h77);
    check("t5_still_valid", 32'(out_valid), 32'd1);
`ifdef CDC_RX_OVERRUN_DETECT_EN
    check("t5_overrun", 32'(overrun), 32'd1);
`endif
    step();
    check("t5_no_overwrite2", 32'(out_data), 32'h77);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_valid_clr", 32'(out_valid), 32'd0);
    check("t5_ack", 32'(ack_toggle), 32'd1);
    step();
    check("t5_recapture_valid", 32'(out_valid), 32'd1);
    check("t5_recapture_data", 32'(out_data), 32'h88);
`ifdef CDC_RX_OVERRUN_DETECT_EN
    check("t5_overrun_sticky", 32'(overrun), 32'd1);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_ack2", 32'(ack_toggle), 32'd0);

    // 6: reset while a word is pending
    data_in = 8'h99; req_sync = ~req_sync;
    step();
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_data", 32'(out_data), 32'h99);
    rst = 1'b1;
    step();
    rst = 1'b0; req_sync = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data_clr", 32'(out_data), 32'h00);
    check("t6_ack", 32'(ack_toggle), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
`ifdef CDC_RX_OVERRUN_DETECT_EN
    check("t6_overrun", 32'(overrun), 32'd0);
`endif
    step();
    check("t6_idle_after", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
